mux_sum_averager: RTL and testbench
===================================

// Module: mux_sum_averager
// PURPOSE
//  Downstream consumer of the 9-bit adder/mux result P. Samples P on IN_VALID and
//  accumulates 2**LOG2N samples per window. At the end of each window it presents
//  the window sum and the mean (the sum shifted right by LOG2N) on a valid/ready
//  output port. A sticky flag records windows lost to output back-pressure.
// PARAMETERS
//  LOG2N   3   log2 of the samples per window (1..8); window length N = 2**LOG2N
// PORTS
//  CLK        in   1          single clock; all logic is rising-edge
//  RST        in   1          asynchronous, active-high reset
//  P_IN       in   9          unsigned sample (adder/mux result)
//  IN_VALID   in   1          sample P_IN this cycle
//  CLR        in   1          synchronous: abort the current window, clear OVERRUN
//  SUM_OUT    out  9+LOG2N    window sum (unsigned, full width, cannot overflow)
//  AVG_OUT    out  9          SUM_OUT >> LOG2N (truncated)
//  OUT_VALID  out  1          result held; high until accepted
//  OUT_READY  in   1          downstream accepts when OUT_VALID && OUT_READY
//  OVERRUN    out  1          sticky: a completed window was dropped
//  SAMPLE_CNT out  LOG2N      samples taken in the current window
// BEHAVIOUR
//  - Reset: acc=0, SAMPLE_CNT=0, SUM_OUT=0, AVG_OUT=0, OUT_VALID=0, OVERRUN=0.
//    Reset is effective at any time, including mid-window; the partial window is lost.
//  - Accumulator width is 9+LOG2N bits. Worst case 511*2**LOG2N fits in that width.
//  - On IN_VALID with SAMPLE_CNT<N-1: acc+=P_IN and SAMPLE_CNT+=1.
//  - On IN_VALID with SAMPLE_CNT==N-1 (final sample): on the next edge
//    SUM_OUT<=acc+P_IN, AVG_OUT<=(acc+P_IN)>>LOG2N, OUT_VALID<=1, acc<=0 and
//    SAMPLE_CNT<=0 (wrap-around). Latency from the final sample to OUT_VALID is 1 cycle.
//  - Sampling never stalls; IN_VALID has no ready. The next window starts
//    immediately after the final sample, and back-to-back IN_VALID is sustained.
//  - Output register states: EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
//     EMPTY -> FULL on window completion.
//     FULL -> EMPTY on OUT_VALID&&OUT_READY with no completion in the same cycle.
//     FULL & completion & OUT_READY: the new result loads and OUT_VALID stays 1
//       (no bubble, no overrun).
//     FULL & completion & !OUT_READY: the held result is kept, the new window is
//       discarded, and OVERRUN<=1.
//  - SUM_OUT and AVG_OUT stay stable while OUT_VALID=1 && !OUT_READY.
//  - CLR: acc<=0, SAMPLE_CNT<=0, OVERRUN<=0. The held output is unaffected.
//    CLR has priority over IN_VALID in the same cycle; that sample is dropped.
// CONFIGURATION
//  MUX_SUM_MINMAX_EN defined: adds ports MAX_OUT[8:0] and MIN_OUT[8:0].
//    These are the max and min of P_IN over the window and are latched with SUM_OUT
//    on completion under the same EMPTY/FULL rules.
//    Per-window trackers are seeded from the window's first sample.
//    Reset values: MAX_OUT=0, MIN_OUT=0x1FF. CLR reseeds the trackers.
//  MUX_SUM_MINMAX_EN undefined: the ports and logic are absent. All other
//    behaviour is identical.
// TESTING
//  1 Reset mid-window: LOG2N=3; 3 samples of 100, assert RST ->
//    all outputs are at reset values; then 8 samples of 10 -> SUM_OUT=80, AVG_OUT=10.
//  2 Max value: 8 consecutive samples of 511, OUT_READY=1 -> 1 cycle after the
//    8th sample: SUM_OUT=4088, AVG_OUT=511, OUT_VALID=1 for 1 cycle.
//  3 Truncation: samples 1,2,3,4,5,6,7,9 -> SUM_OUT=37, AVG_OUT=4.
//  4 Back-pressure: OUT_READY=0; window A (8x20) then window B (8x30) ->
//    SUM_OUT stays 160 and OVERRUN=1; raise OUT_READY -> OUT_VALID falls; CLR -> OVERRUN=0.
//  5 Same-cycle accept and complete: hold window A, assert OUT_READY on window B's
//    final-sample edge -> SUM_OUT=240, OUT_VALID stays 1, OVERRUN=0.
//  6 CLR with IN_VALID: 5 samples, then CLR+IN_VALID together -> SAMPLE_CNT=0;
//    the next 8 samples form a clean window. With MUX_SUM_MINMAX_EN,
//    samples 3,9,1 (plus 5 of 4) -> MAX_OUT=9, MIN_OUT=1.

Source files
------------

// File: rtl/mux_sum_averager.sv
// ---------------------------------------------------------------------------
// mux_sum_averager
//
// Windowed accumulator behind the 9-bit adder/mux result. Each IN_VALID
// sample is added into a running sum. After 2**LOG2N samples the window sum
// and its truncated mean are placed in a one-entry output register. That
// register is offered downstream on a valid/ready port. Sampling never stalls.
// If a window completes while the output register is still held, that window
// is dropped and OVERRUN is set. OVERRUN stays set until CLR.
//
// Optional feature (macro MUX_SUM_MINMAX_EN): adds MAX_OUT/MIN_OUT. These
// carry the largest and smallest sample of the window. They are latched
// together with SUM_OUT.
//
// Parameters
//   LOG2N      log2 of samples per window (1..8)
// Ports
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   P_IN       9-bit unsigned sample
//   IN_VALID   take P_IN this cycle
//   CLR        abort current window, clear OVERRUN (wins over IN_VALID)
//   SUM_OUT    held window sum, 9+LOG2N bits
//   AVG_OUT    held window mean (SUM_OUT >> LOG2N)
//   OUT_VALID  output register holds a result
//   OUT_READY  downstream accepts when OUT_VALID && OUT_READY
//   OVERRUN    sticky: a completed window was discarded
//   SAMPLE_CNT samples taken so far in the current window
//   MAX_OUT    (MUX_SUM_MINMAX_EN) held window maximum
//   MIN_OUT    (MUX_SUM_MINMAX_EN) held window minimum
// ---------------------------------------------------------------------------
module mux_sum_averager #(
    parameter int LOG2N = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [8:0]           P_IN,
    input  logic                 IN_VALID,
    input  logic                 CLR,
    output logic [9+LOG2N-1:0]   SUM_OUT,
    output logic [8:0]           AVG_OUT,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 OVERRUN,
`ifdef MUX_SUM_MINMAX_EN
    output logic [8:0]           MAX_OUT,
    output logic [8:0]           MIN_OUT,
`endif
    output logic [LOG2N-1:0]     SAMPLE_CNT
);

    localparam int ACC_W = 9 + LOG2N;
    // The final sample of a window arrives when the counter is all ones.
    localparam logic [LOG2N-1:0] LAST_IDX = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Truncated mean: dropping the low LOG2N bits leaves exactly 9 bits.
    function automatic logic [8:0] mean_trunc(input logic [ACC_W-1:0] s);
        mean_trunc = s[ACC_W-1:LOG2N];
    endfunction

    out_state_t         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LOG2N-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [8:0]         avg_q, avg_d;
    logic               ovr_q, ovr_d;

    logic               take;
    logic               last;
    logic               load;
    logic [ACC_W-1:0]   win_sum;

`ifdef MUX_SUM_MINMAX_EN
    function automatic logic [8:0] max9(input logic [8:0] a, input logic [8:0] b);
        max9 = (a > b) ? a : b;
    endfunction

    function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
        min9 = (a < b) ? a : b;
    endfunction

    logic [8:0] trk_max_q, trk_max_d;
    logic [8:0] trk_min_q, trk_min_d;
    logic [8:0] win_max, win_min;
    logic [8:0] max_q, max_d;
    logic [8:0] min_q, min_d;
`endif

    // ---- accumulate / window completion ----
    always_comb begin
        take    = IN_VALID && !CLR;
        last    = take && (cnt_q == LAST_IDX);
        win_sum = acc_q + ACC_W'(P_IN);

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (CLR) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (take) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = win_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

`ifdef MUX_SUM_MINMAX_EN
    // The first sample of a window seeds the trackers. Because CLR zeroes the
    // counter, CLR also reseeds the trackers.
    always_comb begin
        win_max = (cnt_q == '0) ? P_IN : max9(trk_max_q, P_IN);
        win_min = (cnt_q == '0) ? P_IN : min9(trk_min_q, P_IN);

        trk_max_d = trk_max_q;
        trk_min_d = trk_min_q;
        if (take) begin
            trk_max_d = win_max;
            trk_min_d = win_min;
        end
    end
`endif

    // ---- output register: EMPTY/FULL handshake ----
    always_comb begin
        // A finished window loads if the register is free, or if the held
        // result is consumed in this same cycle.
        load    = last && ((state_q == EMPTY) || OUT_READY);
        state_d = state_q;
        case (state_q)
            EMPTY:   if (last) state_d = FULL;
            FULL:    if (OUT_READY && !last) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        ovr_d = ovr_q;
        if (CLR) begin
            ovr_d = 1'b0;
        end else if (last && (state_q == FULL) && !OUT_READY) begin
            ovr_d = 1'b1;
        end

        sum_d = load ? win_sum : sum_q;
        avg_d = load ? mean_trunc(win_sum) : avg_q;
`ifdef MUX_SUM_MINMAX_EN
        max_d = load ? win_max : max_q;
        min_d = load ? win_min : min_q;
`endif
    end

    // ---- state registers ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            avg_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            avg_q   <= avg_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef MUX_SUM_MINMAX_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            trk_max_q <= '0;
            trk_min_q <= 9'h1FF;
            max_q     <= '0;
            min_q     <= 9'h1FF;
        end else begin
            trk_max_q <= trk_max_d;
            trk_min_q <= trk_min_d;
            max_q     <= max_d;
            min_q     <= min_d;
        end
    end

    assign MAX_OUT = max_q;
    assign MIN_OUT = min_q;
`endif

    assign SUM_OUT    = sum_q;
    assign AVG_OUT    = avg_q;
    assign OUT_VALID  = (state_q == FULL);
    assign OVERRUN    = ovr_q;
    assign SAMPLE_CNT = cnt_q;

endmodule

// File: tb/tb_mux_sum_averager.sv
// ---------------------------------------------------------------------------
// tb_mux_sum_averager
//
// Directed bench for mux_sum_averager with LOG2N=3. A reference model keeps
// the samples of the current window in a queue. It derives sum, mean and
// extremes directly from that queue. A compare process checks the DUT against
// the model on every falling edge. Hand-computed literal checks follow the
// key steps of each scenario.
// ---------------------------------------------------------------------------
module tb_mux_sum_averager;

    localparam int LOG2N = 3;
    localparam int N     = 1 << LOG2N;

    logic               CLK = 1'b0;
    logic               RST;
    logic [8:0]         P_IN;
    logic               IN_VALID;
    logic               CLR;
    logic [9+LOG2N-1:0] SUM_OUT;
    logic [8:0]         AVG_OUT;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic               OVERRUN;
    logic [LOG2N-1:0]   SAMPLE_CNT;
`ifdef MUX_SUM_MINMAX_EN
    logic [8:0]         MAX_OUT;
    logic [8:0]         MIN_OUT;
`endif

    mux_sum_averager #(.LOG2N(LOG2N)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_IN       (P_IN),
        .IN_VALID   (IN_VALID),
        .CLR        (CLR),
        .SUM_OUT    (SUM_OUT),
        .AVG_OUT    (AVG_OUT),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OVERRUN    (OVERRUN),
`ifdef MUX_SUM_MINMAX_EN
        .MAX_OUT    (MAX_OUT),
        .MIN_OUT    (MIN_OUT),
`endif
        .SAMPLE_CNT (SAMPLE_CNT)
    );

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int  win_q[$];
    bit  m_valid;
    bit  m_ovr;
    int  m_sum, m_avg, m_max, m_min;

    task automatic model_reset();
        win_q.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_sum   = 0;
        m_avg   = 0;
        m_max   = 0;
        m_min   = 511;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                model_reset();
            end else begin
                bit done;
                int s, mx, mn;
                done = 1'b0;
                s = 0; mx = 0; mn = 511;
                if (CLR) begin
                    win_q.delete();
                    m_ovr = 1'b0;
                end else if (IN_VALID) begin
                    win_q.push_back(int'(P_IN));
                    if (win_q.size() == N) begin
                        done = 1'b1;
                        foreach (win_q[i]) begin
                            s += win_q[i];
                            if (win_q[i] > mx) mx = win_q[i];
                            if (win_q[i] < mn) mn = win_q[i];
                        end
                        win_q.delete();
                    end
                end
                if (done && (!m_valid || OUT_READY)) begin
                    m_valid = 1'b1;
                    m_sum   = s;
                    m_avg   = s / N;
                    m_max   = mx;
                    m_min   = mn;
                end else if (done) begin
                    m_ovr = 1'b1;
                end else if (m_valid && OUT_READY) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge CLK);
            chk("valid", int'(OUT_VALID), int'(m_valid));
            chk("overrun", int'(OVERRUN), int'(m_ovr));
            chk("cnt", int'(SAMPLE_CNT), win_q.size());
            if (m_valid) begin
                chk("sum", int'(SUM_OUT), m_sum);
                chk("avg", int'(AVG_OUT), m_avg);
`ifdef MUX_SUM_MINMAX_EN
                chk("max", int'(MAX_OUT), m_max);
                chk("min", int'(MIN_OUT), m_min);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic send(input int p);
        IN_VALID = 1'b1;
        P_IN     = 9'(p);
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic send_n(input int p, input int n);
        for (int i = 0; i < n; i++) send(p);
    endtask

    initial begin
        int t3[8];
        int t6[8];
        t3 = '{1, 2, 3, 4, 5, 6, 7, 9};
        t6 = '{3, 9, 1, 4, 4, 4, 4, 4};

        RST = 1'b1; P_IN = '0; IN_VALID = 1'b0; CLR = 1'b0; OUT_READY = 1'b0;
        tick(); tick();
        chk("rst_sum", int'(SUM_OUT), 0);
        chk("rst_avg", int'(AVG_OUT), 0);
        chk("rst_valid", int'(OUT_VALID), 0);
        chk("rst_ovr", int'(OVERRUN), 0);
`ifdef MUX_SUM_MINMAX_EN
        chk("rst_max", int'(MAX_OUT), 0);
        chk("rst_min", int'(MIN_OUT), 511);
`endif
        RST = 1'b0;
        tick();

        // 1: reset in mid-window
        OUT_READY = 1'b1;
        send_n(100, 3);
        chk("t1_cnt3", int'(SAMPLE_CNT), 3);
        RST = 1'b1;
        #1;
        chk("t1_rst_cnt", int'(SAMPLE_CNT), 0);
        chk("t1_rst_valid", int'(OUT_VALID), 0);
        chk("t1_rst_sum", int'(SUM_OUT), 0);
        tick();
        RST = 1'b0;
        send_n(10, 8);
        chk("t1_sum", int'(SUM_OUT), 80);
        chk("t1_avg", int'(AVG_OUT), 10);
        chk("t1_valid", int'(OUT_VALID), 1);
        tick();

        // 2: all-ones samples, single-cycle valid
        send_n(511, 8);
        chk("t2_sum", int'(SUM_OUT), 4088);
        chk("t2_avg", int'(AVG_OUT), 511);
        chk("t2_valid", int'(OUT_VALID), 1);
        tick();
        chk("t2_valid_drop", int'(OUT_VALID), 0);

        // 3: mean truncation
        for (int i = 0; i < 8; i++) send(t3[i]);
        chk("t3_sum", int'(SUM_OUT), 37);
        chk("t3_avg", int'(AVG_OUT), 4);
        tick();

        // 4: back-pressure drops window B
        OUT_READY = 1'b0;
        send_n(20, 8);
        send_n(30, 8);
        chk("t4_sum_held", int'(SUM_OUT), 160);
        chk("t4_ovr", int'(OVERRUN), 1);
        chk("t4_valid_held", int'(OUT_VALID), 1);
        OUT_READY = 1'b1;
        tick();
        chk("t4_valid_drop", int'(OUT_VALID), 0);
        chk("t4_ovr_sticky", int'(OVERRUN), 1);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("t4_ovr_clr", int'(OVERRUN), 0);

        // 5: accept and complete on the same edge
        OUT_READY = 1'b0;
        send_n(20, 8);
        send_n(30, 7);
        chk("t5_held", int'(SUM_OUT), 160);
        OUT_READY = 1'b1;
        send(30);
        chk("t5_sum", int'(SUM_OUT), 240);
        chk("t5_valid", int'(OUT_VALID), 1);
        chk("t5_ovr", int'(OVERRUN), 0);
        tick();
        chk("t5_valid_drop", int'(OUT_VALID), 0);

        // 6: CLR beats IN_VALID, then a clean window
        send_n(200, 5);
        CLR = 1'b1; IN_VALID = 1'b1; P_IN = 9'd50;
        tick();
        CLR = 1'b0; IN_VALID = 1'b0;
        chk("t6_cnt", int'(SAMPLE_CNT), 0);
        for (int i = 0; i < 8; i++) send(t6[i]);
        chk("t6_sum", int'(SUM_OUT), 33);
        chk("t6_avg", int'(AVG_OUT), 4);
`ifdef MUX_SUM_MINMAX_EN
        chk("t6_max", int'(MAX_OUT), 9);
        chk("t6_min", int'(MIN_OUT), 1);
`endif
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
